hazard_ctrl: RTL and testbench

//  Pipeline hazard controller: consumes the forwarding unit's stall requests
//  (no_forwarding_data_*), the MEMP memory-wait and the EXA branch-flush, and

---
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: turns forwarding stalls, memory waits and branch
// flushes into per-stage stall/bubble/flush controls, with counters and a watchdog.
module hazard_ctrl #(
  parameter int CNT_W         = 32,
  parameter int STALL_TIMEOUT = 1024,
  parameter int TO_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             no_forwarding_data_IDR,
  input  logic             no_forwarding_data_EXB,
  input  logic             no_forwarding_data_MEMP,
  input  logic             mem_busy_MEMP,
  input  logic             branch_flush_EXA,
  output logic             stall_IF,
  output logic             stall_IDC,
  output logic             bubble_IDR,
  output logic             stall_IDR,
  output logic             stall_EXB,
  output logic             stall_EXA,
  output logic             stall_MEMP,
  output logic             bubble_MEMR,
  output logic             flush_IDC,
  output logic             flush_IDR,
  output logic             flush_EXB,
  output logic             redirect_en,
  output logic             hazard_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, REPLAY_FLUSH} state_t;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(STALL_TIMEOUT);

  state_t           state_q, state_d;
  logic             flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic             timeout_q, timeout_d;

  logic data_haz, mem_stall, data_stall, do_flush, stall_any;

  assign data_haz = no_forwarding_data_IDR | no_forwarding_data_EXB | no_forwarding_data_MEMP;

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    mem_stall    = 1'b0;
    data_stall   = 1'b0;
    do_flush     = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_busy_MEMP) begin
          mem_stall = 1'b1;
          if (branch_flush_EXA) flush_pend_d = 1'b1;
          state_d = MEM_WAIT;
        end else if (branch_flush_EXA) begin
          do_flush = 1'b1;
        end else if (data_haz) begin
          data_stall = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_busy_MEMP) begin
          mem_stall = 1'b1;
          if (branch_flush_EXA) flush_pend_d = 1'b1;
        end else begin
          // The flush is deferred one cycle so the released load can leave MEMP first.
          flush_pend_d = flush_pend_q | branch_flush_EXA;
          state_d      = (flush_pend_q || branch_flush_EXA) ? REPLAY_FLUSH : RUN;
          data_stall   = data_haz;
        end
      end
      REPLAY_FLUSH: begin
        if (mem_busy_MEMP) begin
          mem_stall = 1'b1;
        end else begin
          do_flush     = 1'b1;
          flush_pend_d = 1'b0;
          state_d      = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    stall_any   = mem_stall | data_stall;
    stall_cnt_d = (stall_any && stall_cnt_q != {CNT_W{1'b1}}) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (do_flush && flush_cnt_q != {CNT_W{1'b1}}) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    if (!stall_any)        wd_d = '0;
    else if (wd_q != TO_LIM) wd_d = wd_q + TO_W'(1);
    else                   wd_d = wd_q;
    timeout_d = timeout_q | (wd_d == TO_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      flush_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      wd_q         <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      wd_q         <= wd_d;
      timeout_q    <= timeout_d;
    end
  end

  // Controls are combinational, so they are gated directly by reset.
  assign stall_IF    = rst_n & (mem_stall | data_stall);
  assign stall_IDC   = rst_n & (mem_stall | data_stall);
  assign bubble_IDR  = rst_n & data_stall;
  assign stall_IDR   = rst_n & mem_stall;
  assign stall_EXB   = rst_n & mem_stall;
  assign stall_EXA   = rst_n & mem_stall;
  assign stall_MEMP  = rst_n & mem_stall;
  assign bubble_MEMR = rst_n & mem_stall;
  assign flush_IDC   = rst_n & do_flush;
  assign flush_IDR   = rst_n & do_flush;
  assign flush_EXB   = rst_n & do_flush;
  assign redirect_en = rst_n & do_flush;

  assign hazard_timeout = timeout_q;
  assign stall_cnt      = stall_cnt_q;
  assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed literal checks followed by random stimulus
// compared every cycle against a behavioural model.
module tb_hazard_ctrl;
  localparam int CNT_W = 6;
  localparam int TMO   = 8;
  localparam int TO_W  = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic nf_idr = 1'b0, nf_exb = 1'b0, nf_memp = 1'b0, busy = 1'b0, br = 1'b0;
  logic stall_IF, stall_IDC, bubble_IDR, stall_IDR, stall_EXB, stall_EXA, stall_MEMP;
  logic bubble_MEMR, flush_IDC, flush_IDR, flush_EXB, redirect_en, hazard_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.CNT_W(CNT_W), .STALL_TIMEOUT(TMO), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .no_forwarding_data_IDR(nf_idr), .no_forwarding_data_EXB(nf_exb),
    .no_forwarding_data_MEMP(nf_memp), .mem_busy_MEMP(busy), .branch_flush_EXA(br),
    .stall_IF(stall_IF), .stall_IDC(stall_IDC), .bubble_IDR(bubble_IDR),
    .stall_IDR(stall_IDR), .stall_EXB(stall_EXB), .stall_EXA(stall_EXA),
    .stall_MEMP(stall_MEMP), .bubble_MEMR(bubble_MEMR), .flush_IDC(flush_IDC),
    .flush_IDR(flush_IDR), .flush_EXB(flush_EXB), .redirect_en(redirect_en),
    .hazard_timeout(hazard_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: waiting = inside a memory wait, replay = deferred flush due.
  bit m_wait, m_replay, m_pend, m_to;
  int m_scnt, m_fcnt, m_wd;

  function automatic logic [11:0] model_out();
    logic dh, ms, fl, ds;
    dh = nf_idr | nf_exb | nf_memp;
    ms = busy;
    fl = !busy && (m_replay || (!m_wait && br));
    ds = !busy && !m_replay && dh && !(br && !m_wait);
    return {ms | ds, ms | ds, ds, ms, ms, ms, ms, ms, fl, fl, fl, fl};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait = 0; m_replay = 0; m_pend = 0; m_to = 0;
      m_scnt = 0; m_fcnt = 0; m_wd = 0;
    end else begin
      logic [11:0] o;
      bit stall, fl, nw, nr;
      o = model_out();
      stall = o[11];
      fl = o[0];
      if (stall && m_scnt < CMAX) m_scnt++;
      if (fl && m_fcnt < CMAX) m_fcnt++;
      m_wd = stall ? m_wd + 1 : 0;
      if (m_wd >= TMO) m_to = 1;
      nw = !m_replay && busy;
      nr = m_replay ? busy : (m_wait && !busy && (m_pend || br));
      if (busy && br) m_pend = 1;
      if (m_replay && !busy) m_pend = 0;
      m_wait = nw;
      m_replay = nr;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [11:0] exp;
    exp = rst_n ? model_out() : 12'h0;
    chk("ctrl", {stall_IF, stall_IDC, bubble_IDR, stall_IDR, stall_EXB, stall_EXA, stall_MEMP,
                 bubble_MEMR, flush_IDC, flush_IDR, flush_EXB, redirect_en}, exp);
    chk("stall_cnt", stall_cnt, m_scnt);
    chk("flush_cnt", flush_cnt, m_fcnt);
    chk("hazard_timeout", hazard_timeout, m_to);
  end

  task automatic drive(input logic i, input logic e, input logic m, input logic b, input logic f);
    @(posedge clk); #1;
    nf_idr = i; nf_exb = e; nf_memp = m; busy = b; br = f;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0; nf_idr = 0; nf_exb = 0; nf_memp = 0; busy = 0; br = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    do_reset();
    chk("reset stall_cnt", stall_cnt, 0);
    chk("reset timeout", hazard_timeout, 0);
    chk("reset stall_IF", stall_IF, 0);

    // 1: EXB data hazard for 3 cycles
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 0);
      chk("t1 stall_IF", stall_IF, 1);
      chk("t1 bubble_IDR", bubble_IDR, 1);
      chk("t1 stall_EXB", stall_EXB, 0);
    end
    drive(0, 0, 0, 0, 0);
    chk("t1 stall_IF off", stall_IF, 0);
    chk("t1 stall_cnt", stall_cnt, 3);
    chk("t1 flush_cnt", flush_cnt, 0);

    // 2: branch flush overrides data hazard
    do_reset();
    drive(0, 1, 0, 0, 1);
    chk("t2 redirect", redirect_en, 1);
    chk("t2 flush_IDR", flush_IDR, 1);
    chk("t2 bubble_IDR", bubble_IDR, 0);
    drive(0, 0, 0, 0, 0);
    chk("t2 redirect off", redirect_en, 0);
    chk("t2 flush_cnt", flush_cnt, 1);

    // 3: branch during memory wait is replayed one cycle after release
    do_reset();
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1);
    chk("t3 no flush in wait", flush_IDC, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("t3 stall_MEMP", stall_MEMP, 1);
    drive(0, 0, 0, 0, 0);
    chk("t3 release no redirect", redirect_en, 0);
    drive(0, 0, 0, 0, 0);
    chk("t3 replay redirect", redirect_en, 1);
    chk("t3 replay flush_EXB", flush_EXB, 1);
    drive(0, 0, 0, 0, 0);
    chk("t3 redirect once", redirect_en, 0);
    chk("t3 flush_cnt", flush_cnt, 1);

    // 4: memory wait outranks data hazard
    do_reset();
    drive(1, 0, 0, 1, 0);
    chk("t4 stall_MEMP", stall_MEMP, 1);
    chk("t4 bubble_MEMR", bubble_MEMR, 1);
    chk("t4 bubble_IDR", bubble_IDR, 0);
    chk("t4 stall_IF", stall_IF, 1);

    // 5: watchdog after TMO consecutive stall cycles, sticky
    do_reset();
    for (int k = 0; k < TMO; k++) drive(1, 0, 0, 0, 0);
    chk("t5 timeout early", hazard_timeout, 0);
    drive(0, 0, 0, 0, 0);
    chk("t5 timeout set", hazard_timeout, 1);
    drive(0, 0, 0, 0, 0);
    chk("t5 timeout sticky", hazard_timeout, 1);
    do_reset();
    chk("t5 timeout cleared", hazard_timeout, 0);

    // 6: reset during a wait with a pending flush
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1);
    #1 rst_n = 0;
    #1;
    chk("t6 stall_MEMP async", stall_MEMP, 0);
    chk("t6 redirect async", redirect_en, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1; busy = 0; br = 0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0);
      chk("t6 no replay", redirect_en, 0);
    end
    chk("t6 stall_cnt", stall_cnt, 0);
    chk("t6 flush_cnt", flush_cnt, 0);

    // Random phase with bursty inputs and occasional resets
    repeat (3000) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 3) == 0) busy = ~busy;
      if ($urandom_range(0, 4) == 0) nf_idr = ~nf_idr;
      nf_exb  = ($urandom_range(0, 9) == 0);
      nf_memp = ($urandom_range(0, 11) == 0);
      br      = ($urandom_range(0, 6) == 0);
    end
    @(posedge clk); #1;
    rst_n = 1; busy = 0; br = 0; nf_idr = 0; nf_exb = 0; nf_memp = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
